// File: rtl/vend_panel_arbiter.sv
// ============================================================================
// Module   : vend_panel_arbiter
// Purpose  : Shares one vending core between panels A and B (round-robin
//            grant, response routing, core reset, optional watchdog abort).
// Options  : VEND_ARB_WATCHDOG_EN enables the session inactivity watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_panel_arbiter #(
   parameter int DRAIN_CYCLES    = 2,
   parameter int SESSION_TIMEOUT = 64
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       REQ_A,
   input  logic       REQ_B,
   input  logic       KEY_A,
   input  logic       KEY_B,
   input  logic [3:0] CODE_A,
   input  logic [3:0] CODE_B,
   input  logic       VALID_A,
   input  logic       VALID_B,
   input  logic       DOOR_A,
   input  logic       DOOR_B,
   input  logic       M_VEND,
   input  logic       M_INVALID_SEL,
   input  logic       M_FAILED_TRAN,
   input  logic [2:0] M_COST,
   output logic       M_RESET,
   output logic       M_CARD_IN,
   output logic       M_KEY_PRESS,
   output logic       M_VALID_TRAN,
   output logic       M_DOOR_OPEN,
   output logic [3:0] M_ITEM_CODE,
   output logic       GNT_A,
   output logic       GNT_B,
   output logic       VEND_A,
   output logic       VEND_B,
   output logic       INVALID_A,
   output logic       INVALID_B,
   output logic       FAIL_A,
   output logic       FAIL_B,
   output logic [2:0] COST
);

   localparam int                 c_DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_START   = 2'd1,
      S_SESSION = 2'd2,
      S_DRAIN   = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
   logic                 pend_a_q, pend_a_d, pend_b_q, pend_b_d;
   logic                 ptr_q, ptr_d;          // 0 favours A, 1 favours B
   logic                 card_in_q, card_in_d;
   logic                 m_reset_q, m_reset_d;
   logic                 vend_q;
   logic [c_DRAIN_W-1:0] drain_q, drain_d;
   logic                 cand_a, cand_b, pick_a, end_session;
   logic                 wd_fire, abort_a, abort_b;

   assign cand_a      = pend_a_q | REQ_A;
   assign cand_b      = pend_b_q | REQ_B;
   assign pick_a      = cand_a & (~cand_b | ~ptr_q);
   assign end_session = M_FAILED_TRAN | (vend_q & ~M_VEND);

`ifdef VEND_ARB_WATCHDOG_EN
   localparam int                c_WD_W     = $clog2(SESSION_TIMEOUT + 1);
   localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(SESSION_TIMEOUT);

   logic [c_WD_W-1:0] wd_q, wd_d;
   logic              activity;
   logic              abort_a_q, abort_b_q;

   assign activity = (gnt_a_q & (KEY_A | VALID_A | DOOR_A)) |
                     (gnt_b_q & (KEY_B | VALID_B | DOOR_B)) | M_VEND;
   assign wd_fire  = (state_q == S_SESSION) && (wd_q == c_WD_LIMIT);

   always_comb begin
      wd_d = '0;
      if (state_q == S_SESSION && !activity && wd_q != c_WD_LIMIT) begin
         wd_d = wd_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wd_q      <= '0;
         abort_a_q <= 1'b0;
         abort_b_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         abort_a_q <= wd_fire & ~end_session & gnt_a_q;
         abort_b_q <= wd_fire & ~end_session & gnt_b_q;
      end
   end

   assign abort_a = abort_a_q;
   assign abort_b = abort_b_q;
`else
   assign wd_fire = 1'b0;
   assign abort_a = 1'b0;
   assign abort_b = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      gnt_a_d   = gnt_a_q;
      gnt_b_d   = gnt_b_q;
      ptr_d     = ptr_q;
      drain_d   = drain_q;
      card_in_d = 1'b0;
      m_reset_d = 1'b0;
      // A request from the panel that already owns the core is dropped.
      pend_a_d  = pend_a_q | (REQ_A & ~gnt_a_q);
      pend_b_d  = pend_b_q | (REQ_B & ~gnt_b_q);
      case (state_q)
         S_IDLE: begin
            if (cand_a || cand_b) begin
               state_d   = S_START;
               card_in_d = 1'b1;
               gnt_a_d   = pick_a;
               gnt_b_d   = ~pick_a;
               if (pick_a) pend_a_d = 1'b0;
               else        pend_b_d = 1'b0;
            end
         end
         S_START: state_d = S_SESSION;
         S_SESSION: begin
            if (end_session || wd_fire) begin
               state_d   = S_DRAIN;
               gnt_a_d   = 1'b0;
               gnt_b_d   = 1'b0;
               ptr_d     = gnt_a_q;
               drain_d   = c_DRAIN_LAST;
               m_reset_d = wd_fire & ~end_session;
            end
         end
         S_DRAIN: begin
            if (drain_q == '0) state_d = S_IDLE;
            else               drain_d = drain_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= S_IDLE;
         gnt_a_q   <= 1'b0;
         gnt_b_q   <= 1'b0;
         pend_a_q  <= 1'b0;
         pend_b_q  <= 1'b0;
         ptr_q     <= 1'b0;
         card_in_q <= 1'b0;
         m_reset_q <= 1'b1;
         vend_q    <= 1'b0;
         drain_q   <= '0;
      end else begin
         state_q   <= state_d;
         gnt_a_q   <= gnt_a_d;
         gnt_b_q   <= gnt_b_d;
         pend_a_q  <= pend_a_d;
         pend_b_q  <= pend_b_d;
         ptr_q     <= ptr_d;
         card_in_q <= card_in_d;
         m_reset_q <= m_reset_d;
         vend_q    <= M_VEND;
         drain_q   <= drain_d;
      end
   end

   assign M_RESET      = m_reset_q;
   assign M_CARD_IN    = card_in_q;
   assign M_KEY_PRESS  = (gnt_a_q & KEY_A)   | (gnt_b_q & KEY_B);
   assign M_VALID_TRAN = (gnt_a_q & VALID_A) | (gnt_b_q & VALID_B);
   assign M_DOOR_OPEN  = (gnt_a_q & DOOR_A)  | (gnt_b_q & DOOR_B);
   assign M_ITEM_CODE  = gnt_a_q ? CODE_A : (gnt_b_q ? CODE_B : 4'd0);

   assign GNT_A     = gnt_a_q;
   assign GNT_B     = gnt_b_q;
   assign VEND_A    = M_VEND & gnt_a_q;
   assign VEND_B    = M_VEND & gnt_b_q;
   assign INVALID_A = M_INVALID_SEL & gnt_a_q;
   assign INVALID_B = M_INVALID_SEL & gnt_b_q;
   assign FAIL_A    = (M_FAILED_TRAN & gnt_a_q) | abort_a;
   assign FAIL_B    = (M_FAILED_TRAN & gnt_b_q) | abort_b;
   assign COST      = (gnt_a_q | gnt_b_q) ? M_COST : 3'd0;

endmodule

`default_nettype wire

// File: tb/tb_vend_panel_arbiter.sv
// ============================================================================
// Module   : tb_vend_panel_arbiter
// Purpose  : Directed self-checking bench for vend_panel_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vend_panel_arbiter;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic       REQ_A, REQ_B, KEY_A, KEY_B, VALID_A, VALID_B, DOOR_A, DOOR_B;
   logic [3:0] CODE_A, CODE_B;
   logic       M_VEND, M_INVALID_SEL, M_FAILED_TRAN;
   logic [2:0] M_COST;
   logic       M_RESET, M_CARD_IN, M_KEY_PRESS, M_VALID_TRAN, M_DOOR_OPEN;
   logic [3:0] M_ITEM_CODE;
   logic       GNT_A, GNT_B, VEND_A, VEND_B, INVALID_A, INVALID_B, FAIL_A, FAIL_B;
   logic [2:0] COST;

   int n_vec  = 0;
   int n_miss = 0;

   vend_panel_arbiter #(.DRAIN_CYCLES(2), .SESSION_TIMEOUT(64)) u_dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .REQ_A(REQ_A), .REQ_B(REQ_B), .KEY_A(KEY_A), .KEY_B(KEY_B),
      .CODE_A(CODE_A), .CODE_B(CODE_B), .VALID_A(VALID_A), .VALID_B(VALID_B),
      .DOOR_A(DOOR_A), .DOOR_B(DOOR_B),
      .M_VEND(M_VEND), .M_INVALID_SEL(M_INVALID_SEL), .M_FAILED_TRAN(M_FAILED_TRAN),
      .M_COST(M_COST), .M_RESET(M_RESET), .M_CARD_IN(M_CARD_IN),
      .M_KEY_PRESS(M_KEY_PRESS), .M_VALID_TRAN(M_VALID_TRAN), .M_DOOR_OPEN(M_DOOR_OPEN),
      .M_ITEM_CODE(M_ITEM_CODE), .GNT_A(GNT_A), .GNT_B(GNT_B),
      .VEND_A(VEND_A), .VEND_B(VEND_B), .INVALID_A(INVALID_A), .INVALID_B(INVALID_B),
      .FAIL_A(FAIL_A), .FAIL_B(FAIL_B), .COST(COST)
   );

   always #5 CLK = ~CLK;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns 2 time units after the rising edge so registered outputs are stable.
   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic clear_inputs();
      REQ_A = 0; REQ_B = 0; KEY_A = 0; KEY_B = 0; VALID_A = 0; VALID_B = 0;
      DOOR_A = 0; DOOR_B = 0; CODE_A = 0; CODE_B = 0;
      M_VEND = 0; M_INVALID_SEL = 0; M_FAILED_TRAN = 0; M_COST = 0;
   endtask

   initial begin
      clear_inputs();
      RESET_N = 1'b0;
      repeat (3) tick();
      check_vec("rst_m_reset", M_RESET, 1);
      check_vec("rst_gnt_a", GNT_A, 0);
      check_vec("rst_gnt_b", GNT_B, 0);
      check_vec("rst_card_in", M_CARD_IN, 0);
      check_vec("rst_item", M_ITEM_CODE, 0);
      check_vec("rst_cost", COST, 0);
      RESET_N = 1'b1;
      #1 check_vec("rst_hold", M_RESET, 1);
      tick();
      check_vec("rst_release", M_RESET, 0);

      // Single session for panel A
      REQ_A = 1; tick(); REQ_A = 0;
      check_vec("a_gnt", GNT_A, 1);
      check_vec("a_card_in", M_CARD_IN, 1);
      check_vec("a_gnt_b", GNT_B, 0);
      KEY_A = 1; CODE_A = 4'd1; VALID_A = 1;
      tick();
      check_vec("a_card_pulse", M_CARD_IN, 0);
      check_vec("a_gnt_hold", GNT_A, 1);
      check_vec("a_item", M_ITEM_CODE, 1);
      check_vec("a_key", M_KEY_PRESS, 1);
      check_vec("a_valid", M_VALID_TRAN, 1);
      KEY_A = 0; VALID_A = 0; DOOR_A = 1;
      #1 check_vec("a_door", M_DOOR_OPEN, 1);
      check_vec("a_key_off", M_KEY_PRESS, 0);
      tick();
      DOOR_A = 0; M_VEND = 1; M_COST = 3'd3;
      #1 check_vec("a_vend", VEND_A, 1);
      check_vec("a_vend_b", VEND_B, 0);
      check_vec("a_cost", COST, 3);
      tick();
      M_VEND = 0;
      #1 check_vec("a_vend_fall", VEND_A, 0);
      check_vec("a_gnt_at_fall", GNT_A, 1);
      KEY_A = 1;
      tick();
      check_vec("a_release", GNT_A, 0);
      check_vec("drain_key", M_KEY_PRESS, 0);
      check_vec("drain_item", M_ITEM_CODE, 0);
      check_vec("drain_cost", COST, 0);
      KEY_A = 0; M_COST = 0;
      REQ_A = 1; tick(); REQ_A = 0;
      check_vec("drain1_gnt", GNT_A, 0);
      tick();
      check_vec("drain2_gnt", GNT_A, 0);
      tick();
      check_vec("pend_regrant", GNT_A, 1);
      check_vec("pend_card_in", M_CARD_IN, 1);

      // Reset mid-session drops pending B
      REQ_B = 1; tick(); REQ_B = 0;
      RESET_N = 0;
      #1 check_vec("async_gnt", GNT_A, 0);
      check_vec("async_m_reset", M_RESET, 1);
      tick();
      RESET_N = 1;
      tick();
      check_vec("rst2_release", M_RESET, 0);
      check_vec("pend_lost0", GNT_B, 0);
      tick();
      check_vec("pend_lost1", GNT_B, 0);

      // Contention and isolation
      REQ_A = 1; REQ_B = 1; tick(); REQ_A = 0; REQ_B = 0;
      check_vec("cont_gnt_a", GNT_A, 1);
      check_vec("cont_gnt_b", GNT_B, 0);
      tick();
      CODE_A = 4'd2; KEY_B = 1; CODE_B = 4'd4; VALID_B = 1; M_INVALID_SEL = 1;
      #1 check_vec("iso_item", M_ITEM_CODE, 2);
      check_vec("iso_key", M_KEY_PRESS, 0);
      check_vec("iso_valid", M_VALID_TRAN, 0);
      check_vec("iso_inv_a", INVALID_A, 1);
      check_vec("iso_inv_b", INVALID_B, 0);
      M_VEND = 1;
      #1 check_vec("iso_vend_b", VEND_B, 0);
      check_vec("iso_vend_a", VEND_A, 1);
      M_VEND = 0; M_INVALID_SEL = 0; M_FAILED_TRAN = 1;
      #1 check_vec("fail_a", FAIL_A, 1);
      check_vec("fail_b", FAIL_B, 0);
      tick();
      M_FAILED_TRAN = 0;
      #1 check_vec("fail_release", GNT_A, 0);
      check_vec("fail_a_off", FAIL_A, 0);
      tick(); tick();
      check_vec("b_wait", GNT_B, 0);
      tick();
      check_vec("b_gnt", GNT_B, 1);
      check_vec("b_card_in", M_CARD_IN, 1);
      check_vec("b_gnt_a", GNT_A, 0);
      tick();
      check_vec("b_item", M_ITEM_CODE, 4);
      check_vec("b_key", M_KEY_PRESS, 1);
      REQ_B = 1; tick(); REQ_B = 0;
      M_FAILED_TRAN = 1;
      #1 check_vec("fail_b_own", FAIL_B, 1);
      tick();
      M_FAILED_TRAN = 0; KEY_B = 0; VALID_B = 0; CODE_B = 0; CODE_A = 0;
      repeat (4) tick();
      check_vec("b_req_ignored", GNT_B, 0);

      // Pointer returned to A after B's session
      REQ_A = 1; REQ_B = 1; tick(); REQ_A = 0; REQ_B = 0;
      check_vec("ptr_gnt_a", GNT_A, 1);
      check_vec("ptr_gnt_b", GNT_B, 0);
      tick();

`ifdef VEND_ARB_WATCHDOG_EN
      begin
         int seen;
         seen = -1;
         for (int i = 0; i < 100; i++) begin
            tick();
            if (M_RESET === 1'b1) begin
               seen = i;
               break;
            end
         end
         check_vec("wd_cycle", seen, 64);
         check_vec("wd_fail_a", FAIL_A, 1);
         check_vec("wd_gnt_a", GNT_A, 0);
         tick();
         check_vec("wd_reset_pulse", M_RESET, 0);
         check_vec("wd_fail_pulse", FAIL_A, 0);
      end
`else
      repeat (100) tick();
      check_vec("nowd_gnt_a", GNT_A, 1);
      check_vec("nowd_m_reset", M_RESET, 0);
      check_vec("nowd_fail_a", FAIL_A, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/vend_panel_arbiter.md
# vend_panel_arbiter

Shares one `vending_machine` core between two customer front panels, A and B. The block does four things:
- grants the core to one panel at a time and routes that panel's controls to the core;
- returns the core's responses only to the granted panel;
- generates the core's reset;
- aborts stalled sessions.

It sits between the two panel input banks and the single core instance.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 2: idle cycles forced on the core between sessions (≥1).
- `SESSION_TIMEOUT`, default 64: inactivity cycles before a session is aborted (≥8).

Ports:
- `CLK` in 1: single clock, rising edge.
- `RESET_N` in 1: reset, asynchronous, active-low.
- `REQ_A`, `REQ_B` in 1: card-insert pulse from each panel.
- `KEY_A`, `KEY_B` in 1: key press from each panel.
- `CODE_A`, `CODE_B` in 4: item code from each panel.
- `VALID_A`, `VALID_B` in 1: valid-transaction from each panel.
- `DOOR_A`, `DOOR_B` in 1: door-open from each panel.
- `M_VEND`, `M_INVALID_SEL`, `M_FAILED_TRAN` in 1: core responses.
- `M_COST` in 3: core cost.
- `M_RESET` out 1: active-high reset to the core.
- `M_CARD_IN`, `M_KEY_PRESS`, `M_VALID_TRAN`, `M_DOOR_OPEN` out 1: core controls.
- `M_ITEM_CODE` out 4: core item code.
- `GNT_A`, `GNT_B` out 1: panel owns the core.
- `VEND_A`, `VEND_B`, `INVALID_A`, `INVALID_B`, `FAIL_A`, `FAIL_B` out 1: per-panel responses.
- `COST` out 3: `M_COST` while a grant is active, else 0.

## Operation
States are `IDLE`, `START`, `SESSION` and `DRAIN`.

**Pending requests**
- `pend_X` sets on a sampled `REQ_X`.
- It clears when X is granted.
- `REQ_X` from the panel already granted is ignored.

**IDLE**
- If any request is pending or arriving, grant it and go to `START`.
- If both A and B are candidates, the round-robin pointer chooses. The pointer favours A out of reset.

**START**
- Lasts exactly one cycle.
- `M_CARD_IN` = 1, `GNT_X` = 1.
- Then go to `SESSION`.

**SESSION**
- Core inputs are taken from the panel X that owns the grant: `M_KEY_PRESS`=`KEY_X`, `M_ITEM_CODE`=`CODE_X`, `M_VALID_TRAN`=`VALID_X`, `M_DOOR_OPEN`=`DOOR_X`.
- The ungranted panel's inputs have no effect on the core.
- End of session is either of:
  - `M_FAILED_TRAN`=1;
  - falling edge of `M_VEND`, detected against a registered copy of `M_VEND`.
- On end of session go to `DRAIN`.

**DRAIN**
- Grant deasserted; all `M_*` control outputs are 0.
- Lasts `DRAIN_CYCLES` cycles, then go to `IDLE`.
- The pointer moves to the other panel.

**Response routing**
- Combinational: `VEND_X` = `M_VEND` & `GNT_X`, `INVALID_X` = `M_INVALID_SEL` & `GNT_X`.
- `FAIL_X` = (`M_FAILED_TRAN` & `GNT_X`) | `abort_X`.

**Simultaneous events**
- If `REQ_B` arrives in the same cycle that A's session ends, `pend_B` is set. B is granted on the first `IDLE` cycle.

## Timing
**Reset values (while `RESET_N`=0)**
- State `IDLE`; `GNT_*`=0; `pend_*`=0; pointer = A; all `M_*` controls 0.
- `M_RESET`=1. It deasserts at the first rising edge after `RESET_N` rises.

**Reset mid-session**
- All state clears immediately.
- Both `pend_*` are lost.

**Latency**
- `REQ_X` is sampled at edge n in `IDLE`.
- `GNT_X` and `M_CARD_IN` are high from edge n to edge n+1.
- `SESSION` begins at edge n+1.

**Grant release**
- Registered.
- `GNT_X` falls one edge after the end-of-session condition is sampled.

**Control outputs**
- `M_RESET` and `M_CARD_IN` are registered.
- The other `M_*` controls are muxed combinationally from the registered grant.

## Configuration
Macro: `VEND_ARB_WATCHDOG_EN`.

With the macro defined:
- An inactivity counter runs in `SESSION`. Its width is clog2(`SESSION_TIMEOUT`+1).
- The counter clears on any cycle where `KEY_X`, `VALID_X`, `DOOR_X` or `M_VEND` is 1.
- When the count reaches `SESSION_TIMEOUT`:
  - `M_RESET`=1 for one cycle;
  - `abort_X`=1 for one cycle, so `FAIL_X` pulses;
  - go to `DRAIN`.

Without the macro:
- No counter is built and `abort_*` is constant 0.
- Sessions end only on core events.

## Test plan
- **Reset**: `RESET_N`=0 for 3 cycles, then release → `M_RESET`=1 until the first edge after release; all other outputs 0.
- **Single session**: A pulses `REQ_A`, keys code 1 with `VALID_A`, then pulses `DOOR_A`; core `M_VEND` rises then falls.
  - `GNT_A`=1 one edge after `REQ_A`.
  - `M_CARD_IN` is a one-cycle pulse.
  - `M_ITEM_CODE`=1.
  - `VEND_A` follows `M_VEND`.
  - `GNT_A` drops one edge after the `M_VEND` fall.
  - `M_*` held 0 for 2 cycles.
- **Contention**: `REQ_A` and `REQ_B` in the same cycle after reset → A granted first, B granted after A's drain; `VEND_B`/`INVALID_B`=0 throughout A's session.
- **Isolation**: during A's session, drive `KEY_B`=1 and `CODE_B`=4 → `M_ITEM_CODE` stays equal to `CODE_A`; `REQ_B` is pended.
- **Failure**: core asserts `M_FAILED_TRAN` in A's session → `FAIL_A`=1 the same cycle, drain, then pointer = B.
- **Watchdog** (`VEND_ARB_WATCHDOG_EN` defined): grant A, no activity for 64 cycles → `M_RESET` and `FAIL_A` one-cycle pulses, then `DRAIN`. Without the macro, `GNT_A` stays 1 indefinitely.
